// File: rtl/ct_lsu_sram_ctrl_pkg.sv
// ct_lsu_sram_ctrl_pkg
//   Shared definitions for the LSU single-port SRAM controller:
//   controller FSM state encoding and response buffer depth.
package ct_lsu_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    READY    = 2'd2
  } ctrl_state_e;

  localparam int unsigned RSP_DEPTH = 2;

endpackage

// File: rtl/ct_lsu_sram_ctrl_rsp_fifo.sv
// ct_lsu_sram_ctrl_rsp_fifo
//   In-order read-response buffer, RSP_DEPTH entries, asynchronously reset to empty.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     push, push_data   write one entry (ignored when full unless popping)
//     pop               consume head entry (ignored when empty)
//     pop_data          head entry, stable until popped
//     full, empty       occupancy flags
module ct_lsu_sram_ctrl_rsp_fifo
  import ct_lsu_sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 52
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CNT_W'(RSP_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A pop frees the head slot in the same edge, so push+pop on full is legal.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ct_lsu_spsram_512x52_ctrl.sv
// ct_lsu_spsram_512x52_ctrl
//   Controller for the 512x52 single-port SRAM macro (A/CEN/GWEN/WEN/D/Q).
//   After reset it sweeps every entry to INIT_VAL, then serves a valid/ready
//   read/write request port with a per-bit write mask. Read data returns in
//   order through a 2-entry response buffer with backpressure.
//   Ports:
//     forever_cpuclk, cpurst       clock, asynchronous active-high reset
//     init_req / init_done         re-run sweep (READY only) / sweep complete
//     req_vld/req_rdy/req_wr/...   request port (addr, wdata, active-high wmask)
//     rsp_vld/rsp_rdy/rsp_rdata    read response port
//     sram_a/cen/gwen/wen/d/q      SRAM macro pins (cen, gwen, wen active-low)
module ct_lsu_spsram_512x52_ctrl
  import ct_lsu_sram_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           DATA_WIDTH = 52,
  parameter int unsigned           DEPTH      = 512,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  inflight;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rd_credit;
  logic                  fire;
  logic                  rd_fire;

  // A read needs a buffer slot for itself: in-flight plus occupancy must stay
  // below two. No credit is taken back from a same-cycle pop.
  assign rd_credit = ~fifo_full & ~(inflight & ~fifo_empty);
  assign req_rdy   = (state == READY) & ~init_req & (req_wr | rd_credit);
  assign fire      = req_vld & req_rdy;
  assign rd_fire   = fire & ~req_wr;
  assign rsp_vld   = ~fifo_empty;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state     <= RST_WAIT;
      cnt       <= '0;
      inflight  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      // Independent of state so a read accepted alongside init_req still lands.
      inflight <= rd_fire;
      case (state)
        RST_WAIT: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= READY;
            cnt       <= '0;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (init_req) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
          end
        end
        default: begin
          state     <= RST_WAIT;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (state)
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt;
        sram_d    = INIT_VAL;
      end
      READY: begin
        sram_cen  = ~fire;
        sram_gwen = ~req_wr;
        sram_wen  = req_wr ? ~req_wmask : '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
      end
      default: ;
    endcase
  end

  ct_lsu_sram_ctrl_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .push      (inflight),
    .push_data (sram_q),
    .pop       (rsp_rdy),
    .pop_data  (rsp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ct_lsu_spsram_512x52_ctrl.sv
// Testbench for ct_lsu_spsram_512x52_ctrl: behavioural SRAM macro, reference
// memory and a response scoreboard queue.
module tb_ct_lsu_spsram_512x52_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 52;
  localparam int unsigned DEPTH = 512;

  logic          clk;
  logic          cpurst;
  logic          init_req;
  logic          init_done;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] smem    [DEPTH];
  logic [DW-1:0] exp_q   [$];
  bit            last_fire;

  ct_lsu_spsram_512x52_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT_VAL   ('0)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .init_req       (init_req),
    .init_done      (init_done),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM macro: masked write (WEN bit 0 = write), Q the cycle after a read.
  always @(posedge clk) begin
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0)
        smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= smem[sram_a];
    end
  end

  // Called 1 time unit after inputs change (inputs change on negedge).
  task automatic sb_sample();
    logic [DW-1:0] e;
    last_fire = (req_vld === 1'b1) && (req_rdy === 1'b1);
    if (last_fire) begin
      if (req_wr)
        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      else
        exp_q.push_back(ref_mem[req_addr]);
    end
    if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_rdata=%h, required no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          errors++;
          $display("FAIL rsp_data: got %h, required %h", rsp_rdata, e);
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    sb_sample();
  endtask

  task automatic idle();
    req_vld  = 1'b0;
    init_req = 1'b0;
  endtask

  // Present a request until accepted (bounded); leaves req_vld high for back-to-back use.
  task automatic do_req(input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
    bit ok;
    ok        = 1'b0;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    for (int i = 0; i < 50; i++) begin
      settle();
      if (last_fire) begin
        ok = 1'b1;
        checks++;
        if (sram_cen !== 1'b0 || sram_gwen !== ~wr || sram_a !== a ||
            sram_wen !== (wr ? ~m : {DW{1'b1}}) || (wr && sram_d !== d)) begin
          errors++;
          $display("FAIL req_pins: got cen=%b gwen=%b a=%h wen=%h d=%h, required cen=0 gwen=%b a=%h",
                   sram_cen, sram_gwen, sram_a, sram_wen, sram_d, ~wr, a);
        end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept: got no acceptance in 50 cycles, required acceptance (wr=%b a=%h)", wr, a);
    end
  endtask

  task automatic drain();
    idle();
    rsp_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding, rsp_vld=%b, required 0 outstanding, rsp_vld=0",
               exp_q.size(), rsp_vld);
    end
  endtask

  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      checks++;
      if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done} !==
          {1'b0, 1'b0, {DW{1'b0}}, AW'(i), {DW{1'b0}}, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sweep[%0d]: got cen=%b gwen=%b wen=%h a=%h d=%h rdy=%b done=%b, required write 0 to a=%h",
                 i, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done, AW'(i));
      end
      @(negedge clk);
    end
    settle();
    checks++;
    if (init_done !== 1'b1 || sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done: got init_done=%b cen=%b, required init_done=1 cen=1", init_done, sram_cen);
    end
    @(negedge clk);
    foreach (ref_mem[k]) ref_mem[k] = '0;
  endtask

  task automatic test_reset();
    req_vld   = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 9'h055;
    req_wdata = '1;
    req_wmask = '1;
    settle();
    checks++;
    if (init_done !== 1'b0 || req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got done=%b rdy=%b vld=%b, required 0 0 0", init_done, req_rdy, rsp_vld);
    end
    checks++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== {DW{1'b1}}) begin
      errors++;
      $display("FAIL reset_ctrl_pins: got cen=%b gwen=%b wen=%h, required 1 1 all-ones", sram_cen, sram_gwen, sram_wen);
    end
    checks++;
    if (sram_a !== '0 || sram_d !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got a=%h d=%h, required 0 0", sram_a, sram_d);
    end
    @(negedge clk);
  endtask

  task automatic test_init_sweep();
    idle();
    cpurst = 1'b0;
    settle();
    checks++;
    if (sram_cen !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_cycle: got cen=%b done=%b, required cen=1 done=0", sram_cen, init_done);
    end
    @(negedge clk);
    check_sweep();
  endtask

  task automatic test_write_read();
    rsp_rdy = 1'b1;
    do_req(1'b1, 9'h1A5, 52'hABCDE, '1);
    req_vld = 1'b1;
    req_wr  = 1'b0;
    settle();
    checks++;
    if (!last_fire) begin
      errors++;
      $display("FAIL rd_accept: got req_rdy=%b, required 1", req_rdy);
    end
    @(negedge clk);
    idle();
    settle();
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency_early: got rsp_vld=%b one cycle after request, required 0", rsp_vld);
    end
    @(negedge clk);
    settle();
    checks++;
    if (rsp_vld !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: got rsp_vld=%b two cycles after request, required 1", rsp_vld);
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_wmask();
    do_req(1'b1, 9'h003, '1, 52'h00000000000FF);
    do_req(1'b0, 9'h003, '0, '0);
    drain();
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 9'h010, 52'h1111_2222_3333, '1);
    do_req(1'b0, 9'h010, '0, '0);
    do_req(1'b1, 9'h010, 52'h4444_5555_6666, '1);
    do_req(1'b0, 9'h010, '0, '0);
    do_req(1'b1, 9'h011, 52'hF_FFFF_FFFF_FFFF, 52'hF_0000_0000_00F0);
    do_req(1'b0, 9'h011, '0, '0);
    do_req(1'b0, 9'h003, '0, '0);
    drain();
  endtask

  task automatic test_backpressure();
    do_req(1'b1, 9'h001, 52'hA_0000_0000_0001, '1);
    do_req(1'b1, 9'h002, 52'hB_0000_0000_0002, '1);
    do_req(1'b1, 9'h003, 52'hC_0000_0000_0003, '1);
    idle();
    @(negedge clk);
    rsp_rdy = 1'b0;
    req_vld = 1'b1;
    req_wr  = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      req_addr = AW'(i);
      settle();
      checks++;
      if (!last_fire) begin
        errors++;
        $display("FAIL bp_read%0d_accept: got req_rdy=%b, required 1", i, req_rdy);
      end
      @(negedge clk);
    end
    req_addr = 9'h003;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_read3_blocked: got req_rdy=%b, required 0", req_rdy);
      end
      checks++;
      if (exp_q.size() == 0 || rsp_vld !== 1'b1 || rsp_rdata !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_hold: got rsp_vld=%b rsp_rdata=%h, required held head entry", rsp_vld, rsp_rdata);
      end
      @(negedge clk);
    end
    req_wr    = 1'b1;
    req_addr  = 9'h007;
    req_wdata = 52'h7_7777_7777_7777;
    req_wmask = '1;
    settle();
    checks++;
    if (!last_fire || sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin
      errors++;
      $display("FAIL bp_write_full: got rdy=%b cen=%b gwen=%b, required 1 0 0", req_rdy, sram_cen, sram_gwen);
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    do_req(1'b0, 9'h003, '0, '0);
    do_req(1'b0, 9'h007, '0, '0);
    drain();
  endtask

  task automatic test_init_req_inflight();
    rsp_rdy  = 1'b1;
    req_vld  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 9'h1A5;
    settle();
    checks++;
    if (!last_fire) begin
      errors++;
      $display("FAIL ir_read_accept: got req_rdy=%b, required 1", req_rdy);
    end
    @(negedge clk);
    req_wr   = 1'b1;
    init_req = 1'b1;
    settle();
    checks++;
    if (req_rdy !== 1'b0 || sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL ir_blocks_req: got req_rdy=%b cen=%b, required 0 1", req_rdy, sram_cen);
    end
    @(negedge clk);
    idle();
    check_sweep();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ir_read_lost: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_sweep();
    init_req = 1'b1;
    settle();
    @(negedge clk);
    init_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      settle();
      @(negedge clk);
    end
    settle();
    checks++;
    if (sram_a !== 9'd100 || sram_cen !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_pos: got a=%h cen=%b, required a=064 cen=0", sram_a, sram_cen);
    end
    #1 cpurst = 1'b1;
    #1;
    checks++;
    if (sram_cen !== 1'b1 || sram_a !== '0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset: got cen=%b a=%h done=%b, required 1 0 0", sram_cen, sram_a, init_done);
    end
    @(negedge clk);
    @(negedge clk);
    cpurst = 1'b0;
    settle();
    checks++;
    if (sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_rst_wait: got cen=%b, required 1", sram_cen);
    end
    @(negedge clk);
    check_sweep();
    do_req(1'b0, 9'h1A5, '0, '0);
    do_req(1'b0, 9'h007, '0, '0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    cpurst    = 1'b1;
    init_req  = 1'b0;
    req_vld   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_rdy   = 1'b1;
    foreach (ref_mem[k]) ref_mem[k] = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_init_sweep();
    test_write_read();
    test_wmask();
    test_back_to_back();
    test_backpressure();
    test_init_req_inflight();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
